// File: rtl/sub_pipe_if.sv
// Operand/result handshake bundle for the sub_pipe prefix subtractor.
// The master side is the operand source plus result sink. The slave side is the subtractor.
interface sub_pipe_if #(
    parameter int W = 6
);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         in_valid;
    logic         in_ready;
    logic         out_ready;
    logic         out_valid;
    logic [W:0]   d;
    logic         borrow;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] h;
    logic [7:0]   count;

    modport master (
        output x, y, in_valid, out_ready,
        input  in_ready, out_valid, d, borrow, g, p, h, count
    );

    modport slave (
        input  x, y, in_valid, out_ready,
        output in_ready, out_valid, d, borrow, g, p, h, count
    );
endinterface

// File: rtl/sub_pipe.sv
// Three-stage Kogge-Stone subtractor computing x - y as x + ~y + 1.
// A single global enable stalls every stage together, so bubbles are preserved.
module sub_pipe #(
    parameter int W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    sub_pipe_if.slave  bus
);

    // One Kogge-Stone level: bit i absorbs the group that ends span bits below it.
    function automatic logic [2*W-1:0] ks_level(input logic [W-1:0] gi,
                                                input logic [W-1:0] pi,
                                                input int           span);
        logic [W-1:0] go;
        logic [W-1:0] po;
        for (int i = 0; i < W; i++) begin
            if (i >= span) begin
                go[i] = gi[i] | (pi[i] & gi[i-span]);
                po[i] = pi[i] & pi[i-span];
            end else begin
                go[i] = gi[i];
                po[i] = pi[i];
            end
        end
        return {go, po};
    endfunction

    logic           en;

    logic [W-1:0]   x_p0_q, y_p0_q;
    logic           vld_p0_q;
    logic [W-1:0]   g_p0, p_p0, h_p0;

    logic [2*W-1:0] gp_l1_p1, gp_l2_p1;
    logic [W-1:0]   gg_p1_q, pp_p1_q, g_p1_q, p_p1_q, h_p1_q;
    logic           vld_p1_q;

    logic [2*W-1:0] gp_p2;
    logic [W:0]     c_p2;
    logic [W:0]     d_p2_d;
    logic           borrow_p2_d;
    logic [W:0]     d_p2_q;
    logic           borrow_p2_q;
    logic [W-1:0]   g_p2_q, p_p2_q, h_p2_q;
    logic           vld_p2_q;

    logic [7:0]     count_q, count_d;

    assign en          = ~vld_p2_q | bus.out_ready;
    assign bus.in_ready = en;

    // Stage 0 -> 1: per-bit terms against the inverted subtrahend, then spans 1 and 2
    assign g_p0     = x_p0_q & ~y_p0_q;
    assign p_p0     = x_p0_q | ~y_p0_q;
    assign h_p0     = x_p0_q ^ ~y_p0_q;
    assign gp_l1_p1 = ks_level(g_p0, p_p0, 1);
    assign gp_l2_p1 = ks_level(gp_l1_p1[2*W-1:W], gp_l1_p1[W-1:0], 2);

    // Stage 1 -> 2: remaining levels, then fold in the constant carry-in of 1
    always_comb begin
        gp_p2 = {gg_p1_q, pp_p1_q};
        for (int lvl = 2; (1 << lvl) < W; lvl++) begin
            gp_p2 = ks_level(gp_p2[2*W-1:W], gp_p2[W-1:0], 1 << lvl);
        end
        c_p2    = '0;
        c_p2[0] = 1'b1;
        for (int i = 0; i < W; i++) begin
            c_p2[i+1] = gp_p2[W+i] | gp_p2[i];
        end
        d_p2_d = '0;
        for (int i = 0; i < W; i++) begin
            d_p2_d[i] = h_p1_q[i] ^ c_p2[i];
        end
        d_p2_d[W]   = ~c_p2[W];
        borrow_p2_d = ~c_p2[W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_p0_q      <= '0;
            y_p0_q      <= '0;
            vld_p0_q    <= 1'b0;
            gg_p1_q     <= '0;
            pp_p1_q     <= '0;
            g_p1_q      <= '0;
            p_p1_q      <= '0;
            h_p1_q      <= '0;
            vld_p1_q    <= 1'b0;
            d_p2_q      <= '0;
            borrow_p2_q <= 1'b0;
            g_p2_q      <= '0;
            p_p2_q      <= '0;
            h_p2_q      <= '0;
            vld_p2_q    <= 1'b0;
        end else if (en) begin
            x_p0_q      <= bus.x;
            y_p0_q      <= bus.y;
            vld_p0_q    <= bus.in_valid;
            gg_p1_q     <= gp_l2_p1[2*W-1:W];
            pp_p1_q     <= gp_l2_p1[W-1:0];
            g_p1_q      <= g_p0;
            p_p1_q      <= p_p0;
            h_p1_q      <= h_p0;
            vld_p1_q    <= vld_p0_q;
            d_p2_q      <= d_p2_d;
            borrow_p2_q <= borrow_p2_d;
            g_p2_q      <= g_p1_q;
            p_p2_q      <= p_p1_q;
            h_p2_q      <= h_p1_q;
            vld_p2_q    <= vld_p1_q;
        end
    end

    assign count_d = (vld_p2_q && bus.out_ready) ? count_q + 8'd1 : count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.out_valid = vld_p2_q;
    assign bus.d         = d_p2_q;
    assign bus.borrow    = borrow_p2_q;
    assign bus.g         = g_p2_q;
    assign bus.p         = p_p2_q;
    assign bus.h         = h_p2_q;
    assign bus.count     = count_q;

endmodule
